// File: rtl/commit_order_unit.sv
// rtl/commit_order_unit.sv - in-order commit buffer for out-of-order completions
//
// Purpose: completions arrive tagged with a seq_num in any order. Each one is parked
// in the slot indexed by its seq_num. The head slot drains into registered commit_*
// outputs, at most one per cycle and strictly in seq_num order, wrapping modulo
// 2**p_seq_num_bits.
//
// Optional feature: define COMMIT_ORDER_BYPASS_EN to let a completion that targets an
// empty head slot go straight to commit_*. This gives a one-cycle commit latency
// instead of two.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   complete_val/_rdy     completion handshake (rdy = !rst)
//   complete_seq_num      slot index of the completing instruction
//   complete_pc/_waddr/_wdata/_wen   completion payload
//   commit_val            one-cycle pulse per committed seq_num (no back-pressure)
//   commit_seq_num        seq_num being committed
//   commit_pc/_waddr/_wdata/_wen     committed payload
//   head_seq_num          next seq_num to commit
//   num_pending           buffered, not yet committed completions
module commit_order_unit #(
  parameter int p_seq_num_bits = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      complete_val,
  output logic                      complete_rdy,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic [31:0]               complete_pc,
  input  logic [4:0]                complete_waddr,
  input  logic [31:0]               complete_wdata,
  input  logic                      complete_wen,
  output logic                      commit_val,
  output logic [p_seq_num_bits-1:0] commit_seq_num,
  output logic [31:0]               commit_pc,
  output logic [4:0]                commit_waddr,
  output logic [31:0]               commit_wdata,
  output logic                      commit_wen,
  output logic [p_seq_num_bits-1:0] head_seq_num,
  output logic [p_seq_num_bits:0]   num_pending
);

  localparam int n_slots = 1 << p_seq_num_bits;
  localparam int cnt_w   = p_seq_num_bits + 1;
  typedef logic [p_seq_num_bits-1:0] seq_t;
  typedef logic [cnt_w-1:0]          cnt_t;

  logic [n_slots-1:0] valid_q, valid_d;
  logic [31:0]        pc_q    [n_slots];
  logic [31:0]        pc_d    [n_slots];
  logic [4:0]         waddr_q [n_slots];
  logic [4:0]         waddr_d [n_slots];
  logic [31:0]        wdata_q [n_slots];
  logic [31:0]        wdata_d [n_slots];
  logic [n_slots-1:0] wen_q, wen_d;

  seq_t        head_q, head_d;
  cnt_t        num_pending_q, num_pending_d;
  logic        commit_val_q, commit_val_d;
  seq_t        commit_seq_num_q, commit_seq_num_d;
  logic [31:0] commit_pc_q, commit_pc_d;
  logic [4:0]  commit_waddr_q, commit_waddr_d;
  logic [31:0] commit_wdata_q, commit_wdata_d;
  logic        commit_wen_q, commit_wen_d;

  logic accept, dup, bypass, write, head_hit;

  assign complete_rdy = !rst;

  always_comb begin
    accept   = complete_val && complete_rdy;
    head_hit = valid_q[head_q];
    // A completion aimed at a slot that is still occupied is discarded; the
    // original payload wins.
    dup      = accept && valid_q[complete_seq_num];
    bypass   = 1'b0;
`ifdef COMMIT_ORDER_BYPASS_EN
    bypass   = accept && !head_hit && (complete_seq_num == head_q);
`endif
    write    = accept && !dup && !bypass;

    valid_d          = valid_q;
    pc_d             = pc_q;
    waddr_d          = waddr_q;
    wdata_d          = wdata_q;
    wen_d            = wen_q;
    head_d           = head_q;
    commit_val_d     = 1'b0;
    commit_seq_num_d = commit_seq_num_q;
    commit_pc_d      = commit_pc_q;
    commit_waddr_d   = commit_waddr_q;
    commit_wdata_d   = commit_wdata_q;
    commit_wen_d     = commit_wen_q;

    if (head_hit) begin
      commit_val_d     = 1'b1;
      commit_seq_num_d = head_q;
      commit_pc_d      = pc_q[head_q];
      commit_waddr_d   = waddr_q[head_q];
      commit_wdata_d   = wdata_q[head_q];
      commit_wen_d     = wen_q[head_q];
      valid_d[head_q]  = 1'b0;
      head_d           = head_q + seq_t'(1);
    end else if (bypass) begin
      commit_val_d     = 1'b1;
      commit_seq_num_d = head_q;
      commit_pc_d      = complete_pc;
      commit_waddr_d   = complete_waddr;
      commit_wdata_d   = complete_wdata;
      commit_wen_d     = complete_wen;
      head_d           = head_q + seq_t'(1);
    end

    // write needs an empty slot and head_hit needs a full one, so they never
    // target the same slot in one cycle.
    if (write) begin
      valid_d[complete_seq_num] = 1'b1;
      pc_d[complete_seq_num]    = complete_pc;
      waddr_d[complete_seq_num] = complete_waddr;
      wdata_d[complete_seq_num] = complete_wdata;
      wen_d[complete_seq_num]   = complete_wen;
    end

    num_pending_d = num_pending_q + cnt_t'(write) - cnt_t'(head_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q          <= '0;
      head_q           <= '0;
      num_pending_q    <= '0;
      commit_val_q     <= 1'b0;
      commit_seq_num_q <= '0;
      commit_pc_q      <= '0;
      commit_waddr_q   <= '0;
      commit_wdata_q   <= '0;
      commit_wen_q     <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      head_q           <= head_d;
      num_pending_q    <= num_pending_d;
      commit_val_q     <= commit_val_d;
      commit_seq_num_q <= commit_seq_num_d;
      commit_pc_q      <= commit_pc_d;
      commit_waddr_q   <= commit_waddr_d;
      commit_wdata_q   <= commit_wdata_d;
      commit_wen_q     <= commit_wen_d;
    end
  end

  // Slot payload is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
    wen_q   <= wen_d;
  end

  assign commit_val     = commit_val_q;
  assign commit_seq_num = commit_seq_num_q;
  assign commit_pc      = commit_pc_q;
  assign commit_waddr   = commit_waddr_q;
  assign commit_wdata   = commit_wdata_q;
  assign commit_wen     = commit_wen_q;
  assign head_seq_num   = head_q;
  assign num_pending    = num_pending_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && complete_val) begin
      assert (!valid_q[complete_seq_num])
        else $warning("commit_order_unit: duplicate completion for seq %0d dropped",
                      complete_seq_num);
    end
  end
`endif

endmodule

// File: tb/tb_commit_order_unit.sv
// tb/tb_commit_order_unit.sv - directed self-checking bench for commit_order_unit
module tb_commit_order_unit;

  localparam int SB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          complete_val;
  logic          complete_rdy;
  logic [SB-1:0] complete_seq_num;
  logic [31:0]   complete_pc;
  logic [4:0]    complete_waddr;
  logic [31:0]   complete_wdata;
  logic          complete_wen;
  logic          commit_val;
  logic [SB-1:0] commit_seq_num;
  logic [31:0]   commit_pc;
  logic [4:0]    commit_waddr;
  logic [31:0]   commit_wdata;
  logic          commit_wen;
  logic [SB-1:0] head_seq_num;
  logic [SB:0]   num_pending;

  int total = 0;
  int bad   = 0;

  commit_order_unit #(.p_seq_num_bits(SB)) dut (
    .clk(clk), .rst(rst),
    .complete_val(complete_val), .complete_rdy(complete_rdy),
    .complete_seq_num(complete_seq_num), .complete_pc(complete_pc),
    .complete_waddr(complete_waddr), .complete_wdata(complete_wdata),
    .complete_wen(complete_wen),
    .commit_val(commit_val), .commit_seq_num(commit_seq_num),
    .commit_pc(commit_pc), .commit_waddr(commit_waddr),
    .commit_wdata(commit_wdata), .commit_wen(commit_wen),
    .head_seq_num(head_seq_num), .num_pending(num_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          val;
    logic [SB-1:0] seq;
    logic [31:0]   pc;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          wen;
    logic          e_val;
    logic [SB-1:0] e_seq;
    logic [31:0]   e_pc;
    logic [4:0]    e_waddr;
    logic [31:0]   e_wdata;
    logic          e_wen;
    logic [SB-1:0] e_head;
    logic [SB:0]   e_pend;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SB-1:0] s, input logic [31:0] pc,
                       input logic [4:0] wa, input logic [31:0] wd, input logic we);
    complete_val     = v;
    complete_seq_num = s;
    complete_pc      = pc;
    complete_waddr   = wa;
    complete_wdata   = wd;
    complete_wen     = we;
  endtask

  task automatic idle();
    drive(1'b0, '0, 32'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic expect_commit(input string name, input logic [SB-1:0] s, input logic [31:0] wd);
    chk({name, "_val"}, {31'b0, commit_val}, 32'd1);
    chk({name, "_seq"}, {29'b0, commit_seq_num}, {29'b0, s});
    chk({name, "_wdata"}, commit_wdata, wd);
  endtask

  initial begin
    // test 1 (seq 0), then test 2 shifted by one (seq 3,2,1 with head at 1)
    vecs[0] = '{1'b1, 3'd0, 32'h200, 5'd3,  32'hAB, 1'b1, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd0, 4'd1};
    vecs[1] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b1, 3'd0, 32'h200, 5'd3,  32'hAB, 1'b1, 3'd1, 4'd0};
    vecs[2] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd1, 4'd0};
    vecs[3] = '{1'b1, 3'd3, 32'h303, 5'd13, 32'h33, 1'b1, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd1, 4'd1};
    vecs[4] = '{1'b1, 3'd2, 32'h302, 5'd12, 32'h22, 1'b0, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd1, 4'd2};
    vecs[5] = '{1'b1, 3'd1, 32'h301, 5'd11, 32'h11, 1'b1, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd1, 4'd3};
    vecs[6] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b1, 3'd1, 32'h301, 5'd11, 32'h11, 1'b1, 3'd2, 4'd2};
    vecs[7] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b1, 3'd2, 32'h302, 5'd12, 32'h22, 1'b0, 3'd3, 4'd1};
    vecs[8] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b1, 3'd3, 32'h303, 5'd13, 32'h33, 1'b1, 3'd4, 4'd0};
    vecs[9] = '{1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 1'b0, 3'd0, 32'h0,   5'd0,  32'h0,  1'b0, 3'd4, 4'd0};

    rst = 1'b1;
    idle();
    tick();
    tick();
    chk("rst_rdy", {31'b0, complete_rdy}, 32'd0);
    chk("rst_val", {31'b0, commit_val}, 32'd0);
    chk("rst_head", {29'b0, head_seq_num}, 32'd0);
    chk("rst_pend", {28'b0, num_pending}, 32'd0);
    chk("rst_wdata", commit_wdata, 32'd0);
    rst = 1'b0;
    #1;
    chk("run_rdy", {31'b0, complete_rdy}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].val, vecs[i].seq, vecs[i].pc, vecs[i].waddr, vecs[i].wdata, vecs[i].wen);
      tick();
      chk($sformatf("v%0d_val", i), {31'b0, commit_val}, {31'b0, vecs[i].e_val});
      chk($sformatf("v%0d_head", i), {29'b0, head_seq_num}, {29'b0, vecs[i].e_head});
      chk($sformatf("v%0d_pend", i), {28'b0, num_pending}, {28'b0, vecs[i].e_pend});
      if (vecs[i].e_val) begin
        chk($sformatf("v%0d_seq", i), {29'b0, commit_seq_num}, {29'b0, vecs[i].e_seq});
        chk($sformatf("v%0d_pc", i), commit_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_waddr", i), {27'b0, commit_waddr}, {27'b0, vecs[i].e_waddr});
        chk($sformatf("v%0d_wdata", i), commit_wdata, vecs[i].e_wdata);
        chk($sformatf("v%0d_wen", i), {31'b0, commit_wen}, {31'b0, vecs[i].e_wen});
      end
    end
    idle();

    // gap: head=4 empty, seq 5 waits until 4 arrives
    drive(1'b1, 3'd5, 32'h405, 5'd5, 32'h55, 1'b1);
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("gap%0d_val", i), {31'b0, commit_val}, 32'd0);
    end
    chk("gap_pend", {28'b0, num_pending}, 32'd1);
    chk("gap_head", {29'b0, head_seq_num}, 32'd4);
    drive(1'b1, 3'd4, 32'h404, 5'd4, 32'h44, 1'b1);
    tick();
    idle();
    chk("gap_fill_val", {31'b0, commit_val}, 32'd0);
    chk("gap_fill_pend", {28'b0, num_pending}, 32'd2);
    tick();
    expect_commit("gap_c4", 3'd4, 32'h44);
    tick();
    expect_commit("gap_c5", 3'd5, 32'h55);
    chk("gap_end_pend", {28'b0, num_pending}, 32'd0);
    tick();
    chk("gap_idle_val", {31'b0, commit_val}, 32'd0);

    // duplicate: head=6 blocked, seq 7 written twice, second dropped
    drive(1'b1, 3'd7, 32'h507, 5'd7, 32'h70, 1'b1);
    tick();
    drive(1'b1, 3'd7, 32'h5FF, 5'd31, 32'hFF, 1'b0);
    tick();
    chk("dup_pend", {28'b0, num_pending}, 32'd1);
    drive(1'b1, 3'd6, 32'h506, 5'd6, 32'h60, 1'b1);
    tick();
    idle();
    tick();
    expect_commit("dup_c6", 3'd6, 32'h60);
    tick();
    expect_commit("dup_c7", 3'd7, 32'h70);
    chk("dup_c7_pc", commit_pc, 32'h507);
    chk("dup_wrap_head", {29'b0, head_seq_num}, 32'd0);
    tick();

    // wrap: 0..7 then 0..2 one per cycle -> 11 back-to-back commits
    for (int i = 0; i < 13; i++) begin
      if (i < 11) drive(1'b1, 3'(i % 8), 32'h600 + 32'(i), 5'(i), 32'h1000 + 32'(i), 1'b1);
      else idle();
      tick();
      if (i >= 1 && i <= 11) begin
        expect_commit($sformatf("wrap%0d", i - 1), 3'((i - 1) % 8), 32'h1000 + 32'(i - 1));
        chk($sformatf("wrap%0d_pend", i), {28'b0, num_pending}, (i <= 10) ? 32'd1 : 32'd0);
      end else begin
        chk($sformatf("wrap%0d_val", i), {31'b0, commit_val}, 32'd0);
      end
    end
    chk("wrap_head", {29'b0, head_seq_num}, 32'd3);

    // reset mid-operation with buffered entries and a same-cycle completion
    drive(1'b1, 3'd5, 32'h705, 5'd5, 32'h75, 1'b1);
    tick();
    drive(1'b1, 3'd6, 32'h706, 5'd6, 32'h76, 1'b1);
    tick();
    chk("pre_rst_pend", {28'b0, num_pending}, 32'd2);
    rst = 1'b1;
    drive(1'b1, 3'd3, 32'h703, 5'd3, 32'h73, 1'b1);
    #1;
    chk("mid_rst_rdy", {31'b0, complete_rdy}, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("mrst_val", {31'b0, commit_val}, 32'd0);
    chk("mrst_pend", {28'b0, num_pending}, 32'd0);
    chk("mrst_head", {29'b0, head_seq_num}, 32'd0);
    chk("mrst_wdata", commit_wdata, 32'd0);
    tick();
    tick();
    chk("post_rst_pend", {28'b0, num_pending}, 32'd0);
    drive(1'b1, 3'd0, 32'h800, 5'd8, 32'h99, 1'b1);
    tick();
    idle();
    chk("post_rst_lat", {31'b0, commit_val}, 32'd0);
    tick();
    expect_commit("post_rst_c0", 3'd0, 32'h99);
    chk("post_rst_head", {29'b0, head_seq_num}, 32'd1);
    tick();
    chk("post_rst_idle", {31'b0, commit_val}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
